set_job_sched: RTL
==================

Name: set_job_sched

Overview:
- Schedules SET (point-in-circle counting) jobs from two independent requesters onto one shared SET core.
- Round-robin arbitration between requesters; captures the winning job and pulses the core's enable.
- Holds the job operands stable for the whole run, captures the candidate count on the core's valid pulse, and returns it to the winner over a valid/ready response channel.
- Sits between the host-side job sources and the SET datapath instance.

Parameters:
WDOG_CYCLES, 511, max cycles in RUN before abort (used only with SET_SCHED_WDOG_EN; a mode-3 run is about 260 cycles)
CAND_W, 8, candidate count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
r0_req  in  1  requester 0 has a job; held until r0_gnt
r0_gnt  out  1  one-cycle accept pulse for requester 0
r0_central  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each
r0_radius  in  12  {r1,r2,r3}, 4 bits each
r0_mode  in  2  0..3 set operation
r1_req / r1_gnt / r1_central / r1_radius / r1_mode  same as r0_*, requester 1
set_en  out  1  one-cycle start pulse to SET core
set_central  out  24  job operands to core, registered
set_radius  out  12  registered
set_mode  out  2  registered
set_busy  in  1  core busy
set_valid  in  1  core done pulse
set_candidate  in  CAND_W  core result, sampled with set_valid
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that owns the result
rsp_candidate  out  CAND_W  captured count
rsp_err  out  1  watchdog abort flag; constant 0 when the feature is compiled out

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous, active-high.
- Reset values:
  - state = IDLE; all outputs 0.
  - Round-robin pointer `last` = 1, so requester 0 wins the first tie.
  - Job registers 0.
- States: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - Grant logic is combinational. If exactly one req is high, that requester is granted. If both are high, grant the one != last.
  - On grant: rN_gnt = 1 that cycle; rN_central/radius/mode and the id are captured on the edge; next state LAUNCH.
  - No req: stay in IDLE.
- LAUNCH:
  - set_en = 1 for exactly this cycle; set_central/radius/mode already hold the captured job.
  - Next state RUN unconditionally.
- RUN:
  - set_* held constant, set_en = 0.
  - On set_valid = 1: capture set_candidate into rsp_candidate; next state RESP.
  - set_busy is informational only; completion is defined by set_valid.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_candidate stable.
  - On rsp_valid & rsp_ready: update last = rsp_id and go to IDLE. rsp_valid drops the next cycle.
- Latency:
  - rN_req high in IDLE to set_en: 1 cycle.
  - set_valid to rsp_valid: 1 cycle.
  - rsp handshake to next possible grant: 1 cycle (grant happens in the IDLE cycle).
- Boundary conditions:
  - Request withdrawn before grant: legal, nothing issued.
  - Both requests held continuously: grants strictly alternate 0,1,0,1.
  - set_valid outside RUN: ignored, no state change.
  - rsp_ready high while not rsp_valid: no effect.
  - req from the requester whose result is pending in RESP: not granted until after the handshake.
  - Reset mid-RUN: returns to IDLE with set_en = 0. The SET core shares rst, so its run is also aborted; the in-flight job is lost and no response is produced.
- Width rule: rsp_candidate is stored with no arithmetic; values 0..64 fit in CAND_W = 8.

Optional Feature:
- Macro: SET_SCHED_WDOG_EN.
- With the macro:
  - A 10-bit counter clears on entering RUN and increments every RUN cycle.
  - When the counter reaches WDOG_CYCLES without set_valid, go to RESP with rsp_err = 1 and rsp_candidate = 0.
  - rsp_err clears on the response handshake.
  - set_valid and the watchdog hitting in the same cycle: set_valid wins, err = 0.
- Without the macro: no counter; rsp_err tied 0; RUN waits indefinitely.

Decomposition:
- Package set_sched_pkg:
  - state encoding constants (IDLE = 0, LAUNCH = 1, RUN = 2, RESP = 3);
  - mode constants (MODE_A = 0, MODE_AND = 1, MODE_XOR = 2, MODE_3 = 3);
  - field widths (COORD_W = 4, CENTRAL_W = 24, RADIUS_W = 12).
- One sub-module, rr_arb2: 2-way round-robin grant from req[1:0] and the last pointer; purely combinational.

Test Plan:
- After reset, r0_req alone with central = 24'h4_4_0_0_0_0, radius = 12'h3_0_0, mode = 0 -> r0_gnt at cycle 0, set_en at cycle 1; core model returns 29 -> rsp_valid with rsp_id = 0, rsp_candidate = 29.
- r0_req and r1_req both held high for 4 jobs -> grant order 0,1,0,1; each rsp_id matches its grant.
- rsp_ready held low for 10 cycles in RESP -> rsp_valid and rsp_candidate stay stable, no new set_en; ready = 1 -> IDLE next cycle, next grant follows.
- set_valid pulsed while in IDLE, then a normal job -> stray pulse ignored, response correct.
- rst asserted 50 cycles into RUN -> all outputs 0 immediately; a subsequent r1 job completes normally.
- With SET_SCHED_WDOG_EN and a core model that never asserts valid -> rsp_valid after WDOG_CYCLES RUN cycles with rsp_err = 1 and rsp_candidate = 0; valid arriving in the same cycle -> rsp_err = 0.

Source files
------------

// File: rtl/set_job_sched_pkg.sv
// Shared types and constants for the SET job scheduler: FSM encoding,
// SET mode codes and operand field widths.
package set_sched_pkg;

  localparam int COORD_W   = 4;
  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [MODE_W-1:0] MODE_A   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_AND = 2'd1;
  localparam logic [MODE_W-1:0] MODE_XOR = 2'd2;
  localparam logic [MODE_W-1:0] MODE_3   = 2'd3;

  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } job_t;

endpackage

// File: rtl/set_job_sched_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that was not served
// last wins. Purely combinational.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/set_job_sched.sv
// Arbitrates jobs from two requesters onto one SET core and returns the
// candidate count over a valid/ready channel. SET_SCHED_WDOG_EN adds a RUN watchdog.
module set_job_sched
  import set_sched_pkg::*;
#(
  parameter int WDOG_CYCLES = 511,
  parameter int CAND_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_req,
  output logic                 r0_gnt,
  input  logic [CENTRAL_W-1:0] r0_central,
  input  logic [RADIUS_W-1:0]  r0_radius,
  input  logic [MODE_W-1:0]    r0_mode,
  input  logic                 r1_req,
  output logic                 r1_gnt,
  input  logic [CENTRAL_W-1:0] r1_central,
  input  logic [RADIUS_W-1:0]  r1_radius,
  input  logic [MODE_W-1:0]    r1_mode,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [CAND_W-1:0]    rsp_candidate,
  output logic                 rsp_err
);

  state_t      r_state, w_next;
  job_t        r_job;
  logic        r_id, r_last;
  logic [CAND_W-1:0] r_cand;
  logic [1:0]  w_req, w_arb, w_gnt;
  job_t        w_job0, w_job1;
  logic        w_wdog_hit;
  logic        w_unused;

  // set_busy is informational; completion is defined by set_valid alone
  assign w_unused = set_busy | (WDOG_CYCLES == 0);

  assign w_req  = {r1_req, r0_req};
  assign w_job0 = {r0_central, r0_radius, r0_mode};
  assign w_job1 = {r1_central, r1_radius, r1_mode};

  rr_arb2 u_arb (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_arb)
  );

  assign w_gnt = (r_state == ST_IDLE) ? w_arb : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (|w_gnt) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_RUN;
      ST_RUN:    if (set_valid || w_wdog_hit) w_next = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    r0_gnt    = w_gnt[0];
    r1_gnt    = w_gnt[1];
    set_en    = (r_state == ST_LAUNCH);
    rsp_valid = (r_state == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_job  <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
      r_cand <= '0;
    end else begin
      if (|w_gnt) begin
        r_id  <= w_gnt[1];
        r_job <= w_gnt[1] ? w_job1 : w_job0;
      end
      if (r_state == ST_RUN && set_valid) r_cand <= set_candidate;
      else if (w_wdog_hit)                r_cand <= '0;
      if (r_state == ST_RESP && rsp_ready) r_last <= r_id;
    end
  end

`ifdef SET_SCHED_WDOG_EN
  localparam logic [9:0] WDOG_LIM = 10'(WDOG_CYCLES - 1);
  logic [9:0] r_wdog;
  logic       r_err;

  // fires on the WDOG_CYCLES-th RUN cycle; a coincident set_valid wins
  assign w_wdog_hit = (r_state == ST_RUN) && !set_valid && (r_wdog == WDOG_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_LAUNCH)   r_wdog <= '0;
      else if (r_state == ST_RUN) r_wdog <= r_wdog + 10'd1;
      if (r_state == ST_RUN && set_valid)       r_err <= 1'b0;
      else if (w_wdog_hit)                      r_err <= 1'b1;
      else if (r_state == ST_RESP && rsp_ready) r_err <= 1'b0;
    end
  end

  assign rsp_err = r_err;
`else
  assign w_wdog_hit = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign set_central   = r_job.central;
  assign set_radius    = r_job.radius;
  assign set_mode      = r_job.mode;
  assign rsp_id        = r_id;
  assign rsp_candidate = r_cand;

endmodule
